// File: rtl/issue_scoreboard_pkg.sv
// Shared types for the issue controller.
//   riscv : architectural register index type.
//   core  : ALU operation encoding, scoreboard bitmap and issue-slot payload.
package riscv;
  typedef logic [4:0] reg_t;
endpackage

package core;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } ALU_OP_t;

  typedef logic [31:0] scoreboard_t;

  typedef struct packed {
    riscv::reg_t rs1;
    riscv::reg_t rs2;
    riscv::reg_t rd;
    logic        writes_rd;
    ALU_OP_t     alu_op;
  } issue_slot_t;
endpackage

// File: rtl/issue_scoreboard_scoreboard.sv
// Pending-write scoreboard.
//   Inputs : decoded operand/dest lookup, accept strobe (set_i), writeback
//            (wb_valid_i/wb_rd_i), flush release of the issue slot's write.
//   Outputs: hazard_o / cap_ok_o for the decoder handshake, busy_o bitmap,
//            inflight_o pending-write count, sticky err_o.
module scoreboard
  import core::*;
#(
  parameter  int MAX_INFLIGHT = 4,
  localparam int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  riscv::reg_t       rs1_i,
  input  riscv::reg_t       rs2_i,
  input  riscv::reg_t       rd_i,
  input  logic              uses_rs1_i,
  input  logic              uses_rs2_i,
  input  logic              writes_rd_i,
  input  logic              set_i,
  input  logic              wb_valid_i,
  input  riscv::reg_t       wb_rd_i,
  input  logic              flush_clr_i,
  input  riscv::reg_t       flush_rd_i,
  output logic              hazard_o,
  output logic              cap_ok_o,
  output scoreboard_t       busy_o,
  output logic [CNT_W-1:0]  inflight_o,
  output logic              err_o
);

  scoreboard_t      busy_q, busy_d;
  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic             err_q, err_d;

  logic rd_counted, set_hit, wb_hit, fl_hit;

  // x0 is never tracked: a write to it neither marks busy nor counts.
  assign rd_counted = writes_rd_i && (rd_i != '0);
  assign set_hit    = set_i && rd_counted;
  assign wb_hit     = wb_valid_i && (wb_rd_i != '0) && busy_q[wb_rd_i];
  // A writeback and flush hitting the same register release it only once.
  assign fl_hit     = flush_clr_i && busy_q[flush_rd_i] &&
                      !(wb_hit && (wb_rd_i == flush_rd_i));

  assign hazard_o = (uses_rs1_i && (rs1_i != '0) && busy_q[rs1_i]) ||
                    (uses_rs2_i && (rs2_i != '0) && busy_q[rs2_i]) ||
                    (rd_counted && busy_q[rd_i]);
  assign cap_ok_o = (inflight_q < CNT_W'(MAX_INFLIGHT)) || !rd_counted;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    busy_d = busy_q;
    err_d  = err_q;
    if (wb_valid_i && (wb_rd_i != '0) && !busy_q[wb_rd_i]) err_d = 1'b1;
    if (wb_hit)  busy_d[wb_rd_i]    = 1'b0;
    if (fl_hit)  busy_d[flush_rd_i] = 1'b0;
    // Accept and writeback never target the same register (WAW stalls it).
    if (set_hit) busy_d[rd_i]       = 1'b1;
    inflight_d = inflight_q + CNT_W'(set_hit) - CNT_W'(wb_hit) - CNT_W'(fl_hit);
  end

  // NOTE: state updates use non-blocking assignments so all flops sample together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q     <= '0;
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  assign busy_o     = busy_q;
  assign inflight_o = inflight_q;
  assign err_o      = err_q;

endmodule

// File: rtl/issue_scoreboard.sv
// Issue controller between decode and execute.
//   dec_*  : decoder handshake (valid/ready) and decoded fields.
//   iss_*  : single registered issue slot towards execute (valid/ready).
//   wb_*   : writeback retiring a pending register write.
//   flush_i: discards the not-yet-consumed issue slot.
//   busy_o / inflight_o / err_o : scoreboard state and sticky protocol error.
module issue_scoreboard
  import core::*;
#(
  parameter  int MAX_INFLIGHT = 4,
  localparam int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dec_valid_i,
  output logic              dec_ready_o,
  input  logic [4:0]        dec_rs1_i,
  input  logic [4:0]        dec_rs2_i,
  input  logic [4:0]        dec_rd_i,
  input  logic              dec_uses_rs1_i,
  input  logic              dec_uses_rs2_i,
  input  logic              dec_writes_rd_i,
  input  core::ALU_OP_t     dec_alu_op_i,
  output logic              iss_valid_o,
  input  logic              iss_ready_i,
  output logic [4:0]        iss_rs1_o,
  output logic [4:0]        iss_rs2_o,
  output logic [4:0]        iss_rd_o,
  output logic              iss_writes_rd_o,
  output core::ALU_OP_t     iss_alu_op_o,
  input  logic              wb_valid_i,
  input  logic [4:0]        wb_rd_i,
  input  logic              flush_i,
  output logic [31:0]       busy_o,
  output logic [CNT_W-1:0]  inflight_o,
  output logic              err_o
);

  issue_slot_t slot_q, slot_d;
  logic        iss_valid_q, iss_valid_d;
  logic        hazard, cap_ok, slot_free, accept, flush_clr;

  assign slot_free   = !iss_valid_q || iss_ready_i;
  assign dec_ready_o = slot_free && !hazard && cap_ok && !flush_i;
  assign accept      = dec_valid_i && dec_ready_o;
  // Flushing a slot that holds a counted write gives its busy bit back.
  assign flush_clr   = flush_i && iss_valid_q && slot_q.writes_rd && (slot_q.rd != '0);

  scoreboard #(.MAX_INFLIGHT(MAX_INFLIGHT)) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .rs1_i       (dec_rs1_i),
    .rs2_i       (dec_rs2_i),
    .rd_i        (dec_rd_i),
    .uses_rs1_i  (dec_uses_rs1_i),
    .uses_rs2_i  (dec_uses_rs2_i),
    .writes_rd_i (dec_writes_rd_i),
    .set_i       (accept),
    .wb_valid_i  (wb_valid_i),
    .wb_rd_i     (wb_rd_i),
    .flush_clr_i (flush_clr),
    .flush_rd_i  (slot_q.rd),
    .hazard_o    (hazard),
    .cap_ok_o    (cap_ok),
    .busy_o      (busy_o),
    .inflight_o  (inflight_o),
    .err_o       (err_o)
  );

  always_comb begin
    slot_d      = slot_q;
    iss_valid_d = iss_valid_q;
    // Flush wins over consumption; accept is already blocked while flushing.
    if (flush_i) begin
      iss_valid_d = 1'b0;
    end else if (accept) begin
      iss_valid_d      = 1'b1;
      slot_d.rs1       = dec_rs1_i;
      slot_d.rs2       = dec_rs2_i;
      slot_d.rd        = dec_rd_i;
      slot_d.writes_rd = dec_writes_rd_i;
      slot_d.alu_op    = dec_alu_op_i;
    end else if (iss_ready_i) begin
      iss_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q      <= '0;
      iss_valid_q <= 1'b0;
    end else begin
      slot_q      <= slot_d;
      iss_valid_q <= iss_valid_d;
    end
  end

  assign iss_valid_o     = iss_valid_q;
  assign iss_rs1_o       = slot_q.rs1;
  assign iss_rs2_o       = slot_q.rs2;
  assign iss_rd_o        = slot_q.rd;
  assign iss_writes_rd_o = slot_q.writes_rd;
  assign iss_alu_op_o    = slot_q.alu_op;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard: reset, throughput, RAW stall and
// release, x0 handling and sticky error, in-flight cap, flush.
module tb_issue_scoreboard;
  import core::*;

  localparam int MAX_INFLIGHT = 4;
  localparam int CNT_W        = $clog2(MAX_INFLIGHT + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             dec_valid_i, dec_ready_o;
  riscv::reg_t      dec_rs1_i, dec_rs2_i, dec_rd_i;
  logic             dec_uses_rs1_i, dec_uses_rs2_i, dec_writes_rd_i;
  ALU_OP_t          dec_alu_op_i;
  logic             iss_valid_o, iss_ready_i;
  riscv::reg_t      iss_rs1_o, iss_rs2_o, iss_rd_o;
  logic             iss_writes_rd_o;
  ALU_OP_t          iss_alu_op_o;
  logic             wb_valid_i;
  riscv::reg_t      wb_rd_i;
  logic             flush_i;
  logic [31:0]      busy_o;
  logic [CNT_W-1:0] inflight_o;
  logic             err_o;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  issue_scoreboard #(.MAX_INFLIGHT(MAX_INFLIGHT)) dut (
    .clk(clk), .rst(rst),
    .dec_valid_i(dec_valid_i), .dec_ready_o(dec_ready_o),
    .dec_rs1_i(dec_rs1_i), .dec_rs2_i(dec_rs2_i), .dec_rd_i(dec_rd_i),
    .dec_uses_rs1_i(dec_uses_rs1_i), .dec_uses_rs2_i(dec_uses_rs2_i),
    .dec_writes_rd_i(dec_writes_rd_i), .dec_alu_op_i(dec_alu_op_i),
    .iss_valid_o(iss_valid_o), .iss_ready_i(iss_ready_i),
    .iss_rs1_o(iss_rs1_o), .iss_rs2_o(iss_rs2_o), .iss_rd_o(iss_rd_o),
    .iss_writes_rd_o(iss_writes_rd_o), .iss_alu_op_o(iss_alu_op_o),
    .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i), .flush_i(flush_i),
    .busy_o(busy_o), .inflight_o(inflight_o), .err_o(err_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dec(input riscv::reg_t rs1, input riscv::reg_t rs2, input riscv::reg_t rd,
                         input logic u1, input logic u2, input logic w, input ALU_OP_t op);
    dec_rs1_i = rs1; dec_rs2_i = rs2; dec_rd_i = rd;
    dec_uses_rs1_i = u1; dec_uses_rs2_i = u2; dec_writes_rd_i = w;
    dec_alu_op_i = op;
  endtask

  task automatic addi(input riscv::reg_t rd, input riscv::reg_t rs1);
    set_dec(rs1, 5'd0, rd, 1'b1, 1'b0, 1'b1, ALU_ADD);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    dec_valid_i = 1'b0; iss_ready_i = 1'b0; wb_valid_i = 1'b0; wb_rd_i = '0; flush_i = 1'b0;
    set_dec('0, '0, '0, 1'b0, 1'b0, 1'b0, ALU_ADD);
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    apply_reset();
    check("rst_iss_valid", 32'(iss_valid_o), 32'd0);
    check("rst_busy", busy_o, 32'h0);
    check("rst_inflight", 32'(inflight_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);

    // Back-to-back independent writes: one per cycle.
    iss_ready_i = 1'b1;
    addi(5'd1, 5'd0); dec_valid_i = 1'b1;
    #1 check("tp_ready1", 32'(dec_ready_o), 32'd1);
    step();
    check("tp_rd1", 32'(iss_rd_o), 32'd1);
    check("tp_busy1", busy_o, 32'h2);
    addi(5'd2, 5'd0);
    #1 check("tp_ready2", 32'(dec_ready_o), 32'd1);
    step();
    check("tp_valid2", 32'(iss_valid_o), 32'd1);
    check("tp_busy2", busy_o, 32'h6);
    check("tp_inflight2", 32'(inflight_o), 32'd2);

    // Asynchronous reset mid-cycle clears everything without an edge.
    dec_valid_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_iss_valid", 32'(iss_valid_o), 32'd0);
    check("arst_busy", busy_o, 32'h0);
    check("arst_inflight", 32'(inflight_o), 32'd0);
    check("arst_iss_rd", 32'(iss_rd_o), 32'd0);
    step();
    rst = 1'b0;
    step();

    // RAW: sub x3,x1,x2 waits for writeback of x1; no same-cycle bypass.
    iss_ready_i = 1'b1;
    addi(5'd1, 5'd0); dec_valid_i = 1'b1;
    step();
    set_dec(5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, ALU_SUB);
    #1 check("raw_stall", 32'(dec_ready_o), 32'd0);
    step();
    check("raw_slot_drained", 32'(iss_valid_o), 32'd0);
    check("raw_busy_held", busy_o, 32'h2);
    wb_valid_i = 1'b1; wb_rd_i = 5'd1;
    #1 check("raw_no_bypass", 32'(dec_ready_o), 32'd0);
    step();
    wb_valid_i = 1'b0;
    check("raw_busy_cleared", busy_o, 32'h0);
    #1 check("raw_ready_after_wb", 32'(dec_ready_o), 32'd1);
    step();
    dec_valid_i = 1'b0;
    check("raw_busy_x3", busy_o, 32'h8);
    check("raw_iss_op", 32'(iss_alu_op_o), 32'(ALU_SUB));
    check("raw_iss_rs2", 32'(iss_rs2_o), 32'd2);
    wb_valid_i = 1'b1; wb_rd_i = 5'd3;
    step();
    wb_valid_i = 1'b0;
    check("raw_inflight_zero", 32'(inflight_o), 32'd0);
    check("raw_no_err", 32'(err_o), 32'd0);

    // x0 destination is never tracked; spurious writeback sets sticky error.
    addi(5'd0, 5'd0); dec_valid_i = 1'b1;
    #1 check("x0_ready", 32'(dec_ready_o), 32'd1);
    step();
    dec_valid_i = 1'b0;
    check("x0_issued", 32'(iss_valid_o), 32'd1);
    check("x0_busy", busy_o, 32'h0);
    check("x0_inflight", 32'(inflight_o), 32'd0);
    wb_valid_i = 1'b1; wb_rd_i = 5'd5;
    step();
    wb_valid_i = 1'b0;
    check("err_set", 32'(err_o), 32'd1);
    check("err_no_state", busy_o, 32'h0);
    step();
    step();
    check("err_sticky", 32'(err_o), 32'd1);

    // In-flight cap: four writes fit, the fifth waits for a writeback.
    apply_reset();
    iss_ready_i = 1'b1;
    dec_valid_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      addi(riscv::reg_t'(i), 5'd0);
      step();
    end
    check("cap_inflight4", 32'(inflight_o), 32'd4);
    check("cap_busy4", busy_o, 32'h1E);
    addi(5'd5, 5'd0);
    #1 check("cap_stall", 32'(dec_ready_o), 32'd0);
    step();
    check("cap_stall_inflight", 32'(inflight_o), 32'd4);
    check("cap_stall_slot", 32'(iss_valid_o), 32'd0);
    // Store: reads x6/x7, writes no register, so the cap does not apply.
    set_dec(5'd6, 5'd7, 5'd0, 1'b1, 1'b1, 1'b0, ALU_ADD);
    #1 check("cap_store_ready", 32'(dec_ready_o), 32'd1);
    step();
    check("cap_store_issued", 32'(iss_valid_o), 32'd1);
    check("cap_store_wr", 32'(iss_writes_rd_o), 32'd0);
    check("cap_store_inflight", 32'(inflight_o), 32'd4);
    addi(5'd5, 5'd0);
    wb_valid_i = 1'b1; wb_rd_i = 5'd1;
    #1 check("cap_wb_same_cycle", 32'(dec_ready_o), 32'd0);
    step();
    wb_valid_i = 1'b0;
    check("cap_after_wb", 32'(inflight_o), 32'd3);
    #1 check("cap_ready_again", 32'(dec_ready_o), 32'd1);
    step();
    dec_valid_i = 1'b0;
    check("cap_fifth_busy", busy_o, 32'h3C);
    check("cap_fifth_rd", 32'(iss_rd_o), 32'd5);
    check("cap_fifth_inflight", 32'(inflight_o), 32'd4);

    // Flush discards a held write to x7 and blocks the pending decode.
    apply_reset();
    iss_ready_i = 1'b0;
    addi(5'd7, 5'd0); dec_valid_i = 1'b1;
    step();
    check("fl_busy7", busy_o, 32'h80);
    addi(5'd8, 5'd0);
    step();
    check("fl_held_valid", 32'(iss_valid_o), 32'd1);
    check("fl_held_rd", 32'(iss_rd_o), 32'd7);
    flush_i = 1'b1; iss_ready_i = 1'b1;
    #1 check("fl_no_accept", 32'(dec_ready_o), 32'd0);
    step();
    flush_i = 1'b0;
    check("fl_valid", 32'(iss_valid_o), 32'd0);
    check("fl_busy", busy_o, 32'h0);
    check("fl_inflight", 32'(inflight_o), 32'd0);
    dec_valid_i = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/issue_scoreboard.md
Name: issue_scoreboard

Overview:
Issue controller between the decoder and the execute stage. Holds one decoded instruction in an output register. Tracks registers with pending writes in a 32-bit scoreboard, and stalls the decoder on RAW/WAW hazards or when the in-flight write limit is reached. Writeback clears scoreboard bits; a flush discards the not-yet-executed issue slot.

Parameters:
MAX_INFLIGHT, 4, max simultaneously pending register writes (1..15)
CNT_W, $clog2(MAX_INFLIGHT+1), width of inflight counter (derived, localparam)

Ports:
clk  in  1  core clock
rst  in  1  asynchronous, active-high reset
dec_valid_i  in  1  decoder presents instruction
dec_ready_o  out  1  controller accepts this cycle
dec_rs1_i / dec_rs2_i / dec_rd_i  in  5 each  register indices
dec_uses_rs1_i / dec_uses_rs2_i / dec_writes_rd_i  in  1 each  operand/dest usage flags
dec_alu_op_i  in  core::ALU_OP_t  ALU operation
iss_valid_o  out  1  issue slot occupied
iss_ready_i  in  1  execute consumes slot
iss_rs1_o / iss_rs2_o / iss_rd_o  out  5 each  registered indices
iss_writes_rd_o  out  1  registered dest flag
iss_alu_op_o  out  core::ALU_OP_t  registered ALU op
wb_valid_i  in  1  writeback retires a register write
wb_rd_i  in  5  retired destination
flush_i  in  1  discard issue slot
busy_o  out  32  scoreboard bitmap, bit i = xi pending
inflight_o  out  CNT_W  pending write count
err_o  out  1  sticky protocol error

Behaviour:
- Reset (async, immediate): iss_valid_o=0; all iss_* fields 0 (alu_op = enum value 0); busy_o=0; inflight_o=0; err_o=0.
- hazard = (uses_rs1 & rs1!=0 & busy[rs1]) | (uses_rs2 & rs2!=0 & busy[rs2]) | (writes_rd & rd!=0 & busy[rd]). Hazard uses registered busy; no same-cycle writeback bypass.
- slot_free = !iss_valid_o | iss_ready_i.
- cap_ok = inflight_o < MAX_INFLIGHT, or the instruction does not write a non-zero rd.
- dec_ready_o (combinational) = slot_free & !hazard & cap_ok & !flush_i. It does not depend on dec_valid_i.
- Accept = dec_valid_i & dec_ready_o. On accept at edge N, the slot is loaded and iss_valid_o=1 after edge N (latency 1).
- Throughput: 1 instruction per cycle when hazard-free and iss_ready_i=1.
- Slot consumed without accept: iss_valid_o=0 next cycle. Slot held with iss_ready_i=0: outputs stable.
- On accept with writes_rd & rd!=0: set busy[rd] and increment inflight.
- Writes with rd=0 never mark busy and never count toward inflight.
- wb_valid_i with wb_rd_i!=0:
  - If busy[wb_rd]: clear it and decrement inflight.
  - If not busy: no state change, err_o set (sticky until reset).
- wb_valid_i with wb_rd_i=0: ignored.
- Simultaneous accept and writeback: both applied; inflight net unchanged when both count. They cannot target the same register, because the WAW check blocks it.
- flush_i: iss_valid_o=0 next cycle. If the slot held a counted write, clear busy[iss_rd_o] and decrement inflight.
  - Flush overrides iss_ready_i in the same cycle; the slot counts as discarded, not consumed.
  - Writeback in the same cycle to a different register is applied normally.
  - Instructions already consumed by execute are unaffected.
- Execute-side consumption (iss_ready_i) never changes busy or inflight; only writeback or flush does.
- inflight never underflows; a decrement is applied only with a matching busy bit cleared.

Decomposition:
- Add to package core: scoreboard_t (logic [31:0]) and issue_slot_t (packed struct: rs1, rs2, rd, writes_rd, alu_op).
- Reuse riscv::reg_t for indices in the bench.
- Sub-module `scoreboard` holds the busy bitmap, set/clear logic, inflight counter, hazard lookup and err_o. The top holds the issue slot and handshake.

Test Plan:
1. Apply rst mid-run with iss_valid_o=1 and busy_o=0x6 -> all outputs 0 immediately, without waiting for a clk edge.
2. riscv::addi(x1,x0,0) then addi(x2,x0,0), dec_valid_i=1, iss_ready_i=1 -> accepted on consecutive cycles; busy_o=0x00000006, inflight_o=2.
3. addi x1, then RR add x3,x1,x2 -> dec_ready_o=0 until wb_valid_i=1/wb_rd_i=1. Accepted the cycle after writeback (no bypass); busy_o=0x8.
4. addi x0,x0,0 -> accepted; busy_o=0, inflight_o=0. Then wb_valid_i with wb_rd_i=5 while x5 not busy -> err_o=1 and stays 1.
5. MAX_INFLIGHT=4, writes to x1..x5, no writeback -> four accepted, fifth stalls with inflight_o=4. Writeback x1 -> fifth accepted next cycle. A store (no rd) is accepted while inflight_o=4.
6. Slot holds write to x7, iss_ready_i=0, flush_i=1 with a dec_valid_i pending -> no accept; next cycle iss_valid_o=0, busy_o[7]=0, inflight decremented by 1.
